// File: rtl/sr_ff_bank.sv
// Bank of WIDTH clocked SR flip-flops with configurable S=R=1 resolution,
// optional NAND-style inputs, edge pulses and a saturating conflict counter.
module sr_ff_bank #(
    parameter int WIDTH      = 8,
    parameter int MODE       = 0,
    parameter int ACTIVE_LOW = 0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] q_rise,
    output logic [WIDTH-1:0] q_fall,
    output logic             conflict,
    output logic             err_sticky,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] sa_s;
    logic [WIDTH-1:0] ra_s;
    logic [WIDTH-1:0] next_q_s;
    logic             conf_s;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] qn_r;
    logic [WIDTH-1:0] rise_r;
    logic [WIDTH-1:0] fall_r;
    logic             conflict_r;
    logic             err_r;
    logic [CNT_W-1:0] cnt_r;

    // Outcome of a simultaneous set and reset on one bit; unknown modes hold.
    function automatic logic resolve(input logic cur);
        case (MODE)
            32'sd1:  resolve = 1'b1;
            32'sd2:  resolve = 1'b0;
            32'sd3:  resolve = ~cur;
            default: resolve = cur;
        endcase
    endfunction

    assign sa_s   = (ACTIVE_LOW != 32'sd0) ? ~s : s;
    assign ra_s   = (ACTIVE_LOW != 32'sd0) ? ~r : r;
    assign conf_s = en & (|(sa_s & ra_s));

    // Per-bit next state from normalised set/reset requests.
    always_comb begin
        next_q_s = q_r;
        for (int i = 0; i < WIDTH; i++) begin
            if (en) begin
                case ({sa_s[i], ra_s[i]})
                    2'b10:   next_q_s[i] = 1'b1;
                    2'b01:   next_q_s[i] = 1'b0;
                    2'b11:   next_q_s[i] = resolve(q_r[i]);
                    default: next_q_s[i] = q_r[i];
                endcase
            end else begin
                next_q_s[i] = q_r[i];
            end
        end
    end

    // State, edge pulses and error bookkeeping; a conflict beats clr_err.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r        <= {WIDTH{1'b0}};
            qn_r       <= {WIDTH{1'b1}};
            rise_r     <= {WIDTH{1'b0}};
            fall_r     <= {WIDTH{1'b0}};
            conflict_r <= 1'b0;
            err_r      <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            q_r        <= next_q_s;
            qn_r       <= ~next_q_s;
            rise_r     <= next_q_s & ~q_r;
            fall_r     <= ~next_q_s & q_r;
            conflict_r <= conf_s;
            if (conf_s) begin
                err_r <= 1'b1;
                if (clr_err) begin
                    cnt_r <= CNT_W'(1);
                end else if (cnt_r != CNT_MAX) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end else begin
                    cnt_r <= cnt_r;
                end
            end else if (clr_err) begin
                err_r <= 1'b0;
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                err_r <= err_r;
                cnt_r <= cnt_r;
            end
        end
    end

    assign q            = q_r;
    assign qn           = qn_r;
    assign q_rise       = rise_r;
    assign q_fall       = fall_r;
    assign conflict     = conflict_r;
    assign err_sticky   = err_r;
    assign conflict_cnt = cnt_r;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Self-checking bench: six sr_ff_bank variants share one stimulus stream and
// are compared against a rule-level model plus directed expected values.
module tb_sr_ff_bank;

    localparam int N = 6;  // 0..3 MODE 0..3, 4 active-low MODE 0, 5 CNT_W=3

    logic       clk = 1'b0;
    logic       rst_n, en, clr_err;
    logic [7:0] s, r;

    logic [7:0] q_o[N], qn_o[N], rise_o[N], fall_o[N], cnt_o[N];
    logic       conf_o[N], err_o[N];
    logic [2:0] cnt5;

    logic [7:0] mq[N], mrise[N], mfall[N];
    logic       mconf[N], merr[N];
    int         mcnt[N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_mode
        sr_ff_bank #(.WIDTH(8), .MODE(g), .ACTIVE_LOW(0), .CNT_W(8)) dut (
            .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_err(clr_err),
            .q(q_o[g]), .qn(qn_o[g]), .q_rise(rise_o[g]), .q_fall(fall_o[g]),
            .conflict(conf_o[g]), .err_sticky(err_o[g]), .conflict_cnt(cnt_o[g]));
    end

    sr_ff_bank #(.WIDTH(8), .MODE(0), .ACTIVE_LOW(1), .CNT_W(8)) dut_al (
        .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_err(clr_err),
        .q(q_o[4]), .qn(qn_o[4]), .q_rise(rise_o[4]), .q_fall(fall_o[4]),
        .conflict(conf_o[4]), .err_sticky(err_o[4]), .conflict_cnt(cnt_o[4]));

    sr_ff_bank #(.WIDTH(8), .MODE(0), .ACTIVE_LOW(0), .CNT_W(3)) dut_c3 (
        .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_err(clr_err),
        .q(q_o[5]), .qn(qn_o[5]), .q_rise(rise_o[5]), .q_fall(fall_o[5]),
        .conflict(conf_o[5]), .err_sticky(err_o[5]), .conflict_cnt(cnt5));
    assign cnt_o[5] = {5'b0, cnt5};

    // One clock edge: the model applies the textual SR rules to the inputs
    // that were presented before the edge, then outputs are sampled at +1.
    task automatic step();
        logic [7:0] sa, ra, nq;
        int mode, cmax;
        bit hit;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            mode = (i < 4) ? i : 0;
            cmax = (i == 5) ? 7 : 255;
            if (!rst_n) begin
                mq[i] = 8'h00; mrise[i] = 8'h00; mfall[i] = 8'h00;
                mconf[i] = 1'b0; merr[i] = 1'b0; mcnt[i] = 0;
            end else begin
                sa = (i == 4) ? ~s : s;
                ra = (i == 4) ? ~r : r;
                nq = mq[i];
                if (en) begin
                    for (int b = 0; b < 8; b++) begin
                        if (sa[b] && !ra[b]) nq[b] = 1'b1;
                        else if (!sa[b] && ra[b]) nq[b] = 1'b0;
                        else if (sa[b] && ra[b]) begin
                            if (mode == 1) nq[b] = 1'b1;
                            else if (mode == 2) nq[b] = 1'b0;
                            else if (mode == 3) nq[b] = !mq[i][b];
                        end
                    end
                end
                hit = en && ((sa & ra) != 8'h00);
                mrise[i] = nq & ~mq[i];
                mfall[i] = ~nq & mq[i];
                mconf[i] = hit;
                if (hit) begin
                    merr[i] = 1'b1;
                    mcnt[i] = clr_err ? 1 : ((mcnt[i] < cmax) ? mcnt[i] + 1 : cmax);
                end else if (clr_err) begin
                    merr[i] = 1'b0;
                    mcnt[i] = 0;
                end
                mq[i] = nq;
            end
        end
        #1;
    endtask

    task automatic drive(input logic rn, input logic e, input logic [7:0] sv,
                         input logic [7:0] rv, input logic c);
        rst_n = rn; en = e; s = sv; r = rv; clr_err = c;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 8'hFF, 8'h00, 1'b1);
        step();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (q_o[i] !== 8'h00 || qn_o[i] !== 8'hFF || rise_o[i] !== 8'h00 ||
                fall_o[i] !== 8'h00 || conf_o[i] !== 1'b0 || err_o[i] !== 1'b0 ||
                cnt_o[i] !== 8'h00) begin
                errors++;
                $display("FAIL reset inst%0d got q=%h qn=%h rise=%h fall=%h conf=%b err=%b cnt=%h want q=00 qn=ff rest 0",
                         i, q_o[i], qn_o[i], rise_o[i], fall_o[i], conf_o[i], err_o[i], cnt_o[i]);
            end
        end
    endtask

    task automatic test_basic();
        drive(1'b1, 1'b1, 8'h0F, 8'h00, 1'b0);
        step();
        checks++;
        if (q_o[0] !== 8'h0F || rise_o[0] !== 8'h0F || qn_o[0] !== 8'hF0) begin
            errors++;
            $display("FAIL basic_set got q=%h rise=%h qn=%h want 0f 0f f0", q_o[0], rise_o[0], qn_o[0]);
        end
        drive(1'b1, 1'b1, 8'h00, 8'h03, 1'b0);
        step();
        checks++;
        if (q_o[0] !== 8'h0C || fall_o[0] !== 8'h03 || rise_o[0] !== 8'h00) begin
            errors++;
            $display("FAIL basic_reset got q=%h fall=%h rise=%h want 0c 03 00", q_o[0], fall_o[0], rise_o[0]);
        end
    endtask

    task automatic test_conflict_modes();
        logic [7:0] want[4];
        want[0] = 8'h0C; want[1] = 8'h0D; want[2] = 8'h08; want[3] = 8'h09;
        drive(1'b1, 1'b1, 8'h05, 8'h05, 1'b0);
        step();
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (q_o[m] !== want[m] || conf_o[m] !== 1'b1 || err_o[m] !== 1'b1 ||
                cnt_o[m] !== 8'd1) begin
                errors++;
                $display("FAIL conflict_mode%0d got q=%h conf=%b err=%b cnt=%0d want q=%h 1 1 1",
                         m, q_o[m], conf_o[m], err_o[m], cnt_o[m], want[m]);
            end
        end
    endtask

    task automatic test_active_low();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        drive(1'b1, 1'b1, 8'hFE, 8'hFF, 1'b0);
        step();
        checks++;
        if (q_o[4] !== 8'h01 || conf_o[4] !== 1'b0) begin
            errors++;
            $display("FAIL al_set got q=%h conf=%b want 01 0", q_o[4], conf_o[4]);
        end
        drive(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0);
        step();
        checks++;
        if (q_o[4] !== 8'h01 || conf_o[4] !== 1'b0) begin
            errors++;
            $display("FAIL al_idle got q=%h conf=%b want 01 0", q_o[4], conf_o[4]);
        end
        drive(1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
        step();
        checks++;
        if (q_o[4] !== 8'h01 || conf_o[4] !== 1'b1 || err_o[4] !== 1'b1) begin
            errors++;
            $display("FAIL al_conflict got q=%h conf=%b err=%b want 01 1 1", q_o[4], conf_o[4], err_o[4]);
        end
    endtask

    task automatic test_saturation();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0);
            step();
        end
        checks++;
        if (cnt_o[5] !== 8'd7 || cnt_o[0] !== 8'd9) begin
            errors++;
            $display("FAIL sat_9 got cnt3=%0d cnt8=%0d want 7 9", cnt_o[5], cnt_o[0]);
        end
        step();
        checks++;
        if (cnt_o[5] !== 8'd7 || err_o[5] !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold got cnt=%0d err=%b want 7 1", cnt_o[5], err_o[5]);
        end
        drive(1'b1, 1'b1, 8'h00, 8'h00, 1'b1);
        step();
        checks++;
        if (cnt_o[5] !== 8'd0 || err_o[5] !== 1'b0 || conf_o[5] !== 1'b0) begin
            errors++;
            $display("FAIL clr_alone got cnt=%0d err=%b conf=%b want 0 0 0", cnt_o[5], err_o[5], conf_o[5]);
        end
        drive(1'b1, 1'b1, 8'h10, 8'h10, 1'b1);
        step();
        checks++;
        if (cnt_o[5] !== 8'd1 || err_o[5] !== 1'b1 || cnt_o[0] !== 8'd1) begin
            errors++;
            $display("FAIL clr_with_conflict got cnt3=%0d err=%b cnt8=%0d want 1 1 1", cnt_o[5], err_o[5], cnt_o[0]);
        end
    endtask

    task automatic test_en_gating();
        logic [7:0] q0, c0;
        drive(1'b1, 1'b1, 8'h3C, 8'h00, 1'b0);
        step();
        q0 = q_o[0];
        c0 = cnt_o[0];
        checks++;
        if (q0 !== 8'h3C) begin
            errors++;
            $display("FAIL gate_setup got q=%h want 3c", q0);
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0);
            step();
            checks++;
            if (q_o[0] !== q0 || conf_o[0] !== 1'b0 || cnt_o[0] !== c0 ||
                rise_o[0] !== 8'h00 || fall_o[0] !== 8'h00) begin
                errors++;
                $display("FAIL en_gate cyc%0d got q=%h conf=%b cnt=%0d rise=%h fall=%h want q=%h 0 cnt=%0d 00 00",
                         k, q_o[0], conf_o[0], cnt_o[0], rise_o[0], fall_o[0], q0, c0);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        drive(1'b1, 1'b1, 8'hAA, 8'h55, 1'b0);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0);
            step();
        end
        checks++;
        if (q_o[0] !== 8'hAA || cnt_o[0] !== 8'd4) begin
            errors++;
            $display("FAIL mid_setup got q=%h cnt=%0d want aa 4", q_o[0], cnt_o[0]);
        end
        drive(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
        step();
        checks++;
        if (q_o[0] !== 8'h00 || qn_o[0] !== 8'hFF || cnt_o[0] !== 8'd0 || conf_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got q=%h qn=%h cnt=%0d conf=%b want 00 ff 0 0",
                     q_o[0], qn_o[0], cnt_o[0], conf_o[0]);
        end
        drive(1'b1, 1'b1, 8'h01, 8'h00, 1'b0);
        step();
        checks++;
        if (q_o[0] !== 8'h01 || rise_o[0] !== 8'h01) begin
            errors++;
            $display("FAIL post_reset got q=%h rise=%h want 01 01", q_o[0], rise_o[0]);
        end
    endtask

    task automatic test_random();
        logic [7:0] rs, rr;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        for (int k = 0; k < 400; k++) begin
            rs = 8'($urandom);
            rr = 8'($urandom);
            if ($urandom_range(0, 1) == 0) rr = rr & ~rs;
            drive(($urandom_range(0, 40) != 0), ($urandom_range(0, 3) != 0), rs, rr,
                  ($urandom_range(0, 7) == 0));
            step();
            for (int i = 0; i < N; i++) begin
                checks++;
                if (q_o[i] !== mq[i] || qn_o[i] !== ~mq[i] || rise_o[i] !== mrise[i] ||
                    fall_o[i] !== mfall[i] || conf_o[i] !== mconf[i] || err_o[i] !== merr[i] ||
                    cnt_o[i] !== 8'(mcnt[i])) begin
                    errors++;
                    $display("FAIL random cyc%0d inst%0d got q=%h qn=%h rise=%h fall=%h conf=%b err=%b cnt=%0d want q=%h qn=%h rise=%h fall=%h conf=%b err=%b cnt=%0d",
                             k, i, q_o[i], qn_o[i], rise_o[i], fall_o[i], conf_o[i], err_o[i], cnt_o[i],
                             mq[i], ~mq[i], mrise[i], mfall[i], mconf[i], merr[i], mcnt[i]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            mq[i] = 8'h00; mrise[i] = 8'h00; mfall[i] = 8'h00;
            mconf[i] = 1'b0; merr[i] = 1'b0; mcnt[i] = 0;
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        #1;
        test_reset();
        test_basic();
        test_conflict_modes();
        test_active_low();
        test_saturation();
        test_en_gating();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_ff_bank.md
SR_FF_BANK -- requirements
Module: sr_ff_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: number of independent SR channels (1..32).
REQ-002 The block SHALL have parameter MODE, default 0: S=R=1 resolution (0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle).
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 0: 1 = NAND-style inputs, where s/r are asserted at logic 0.
REQ-004 The block SHALL have parameter CNT_W, default 8: width of the conflict counter.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port en, input, 1 bit: global update enable.
REQ-008 The block SHALL have port s, input, WIDTH bits: per-channel set request.
REQ-009 The block SHALL have port r, input, WIDTH bits: per-channel reset request.
REQ-010 The block SHALL have port clr_err, input, 1 bit: clears err_sticky and conflict_cnt.
REQ-011 The block SHALL have port q, output, WIDTH bits: registered channel state.
REQ-012 The block SHALL have port qn, output, WIDTH bits: bitwise complement of q at all times.
REQ-013 The block SHALL have port q_rise, output, WIDTH bits: one-cycle pulse on a channel 0->1 transition.
REQ-014 The block SHALL have port q_fall, output, WIDTH bits: one-cycle pulse on a channel 1->0 transition.
REQ-015 The block SHALL have port conflict, output, 1 bit: one-cycle pulse when any channel saw S=R=1 while en=1.
REQ-016 The block SHALL have port err_sticky, output, 1 bit: latched conflict indicator.
REQ-017 The block SHALL have port conflict_cnt, output, CNT_W bits: saturating count of conflict cycles.

Function
REQ-018 The block SHALL normalise inputs as sa = ACTIVE_LOW ? ~s : s and ra = ACTIVE_LOW ? ~r : r; all later rules use sa/ra.
REQ-019 When en=0, every q bit SHALL hold, and conflict, q_rise and q_fall SHALL be 0 on the next cycle.
REQ-020 When en=1, per bit: sa=1,ra=0 -> next q=1; sa=0,ra=1 -> next q=0; sa=0,ra=0 -> hold.
REQ-021 When en=1 and sa=ra=1 on a bit, the bit SHALL resolve per MODE: 0 hold, 1 -> 1, 2 -> 0, 3 -> ~q. No X/undefined state is ever produced.
REQ-022 The latency from a sampled input to q SHALL be exactly one clk cycle, with no combinational path from s/r to q.
REQ-023 q_rise SHALL be registered as next_q & ~q and q_fall as ~next_q & q, so each pulse coincides with the cycle q first shows its new value.
REQ-024 conflict SHALL be registered as en & |(sa & ra): one pulse per conflict cycle regardless of how many bits conflict.
REQ-025 conflict_cnt SHALL increment by 1 on each cycle where the conflict condition is true, and SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-026 err_sticky SHALL be set on a conflict-condition cycle and SHALL hold until clr_err=1.
REQ-027 clr_err=1 without a conflict condition SHALL clear err_sticky to 0 and conflict_cnt to 0 on the next cycle.
REQ-028 When clr_err and a conflict condition occur in the same cycle, the result SHALL be err_sticky=1 and conflict_cnt=1 (the set wins).
REQ-029 clr_err SHALL NOT affect q, qn, q_rise or q_fall.

Reset
REQ-030 When rst_n=0 at a clk edge: q=0, qn=all ones, q_rise=0, q_fall=0, conflict=0, err_sticky=0, conflict_cnt=0.
REQ-031 Reset SHALL take priority over en, s, r and clr_err, including mid-sequence and during a conflict.
REQ-032 No output SHALL change between clock edges due to rst_n; there is no asynchronous reset path.
REQ-033 The first cycle after reset release SHALL process inputs normally, with no dead cycle.

Verification
REQ-034 The bench SHALL cover basic set/reset: WIDTH=8, MODE=0, en=1, s=0x0F,r=0 -> next cycle q=0x0F, q_rise=0x0F; then s=0,r=0x03 -> q=0x0C, q_fall=0x03.
REQ-035 The bench SHALL cover the conflict modes: q=0x0C, s=r=0x05 -> MODE0 q=0x0C; MODE1 q=0x0D; MODE2 q=0x08; MODE3 q=0x09. conflict=1, err_sticky=1, conflict_cnt=1 in every mode.
REQ-036 The bench SHALL cover NAND-style inputs: ACTIVE_LOW=1, s=0xFE,r=0xFF -> q bit0=1; s=r=0xFF -> hold; s=r=0x00 with MODE0 -> q held, conflict=1.
REQ-037 The bench SHALL cover counter saturation: CNT_W=3 with 9 consecutive conflict cycles -> conflict_cnt=7 and stays 7. Then clr_err alone -> cnt=0, err_sticky=0; clr_err with a conflict -> cnt=1, err_sticky=1.
REQ-038 The bench SHALL cover en gating: en=0, s=0xFF, r=0xFF for 5 cycles -> q unchanged, conflict=0, cnt unchanged.
REQ-039 The bench SHALL cover reset mid-operation: q=0xAA, cnt=4, rst_n=0 for one edge while s=0xFF -> q=0, qn=0xFF, cnt=0. rst_n=1 with s=0x01 -> q=0x01 one cycle later.
